// File: rtl/sram_arbiter_if.sv
// Bundle of CPU-side request/response signals and SRAM-controller-side bus signals.
// The slave modport is the arbiter's view. The master modport is the view of the CPU and the SRAM environment.
interface sram_arbiter_if;
  logic        inst_re_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_data_o;
  logic        inst_ack_o;
  logic        inst_stall_o;

  logic        data_re_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_mask_i;
  logic [31:0] data_rdata_o;
  logic        data_ack_o;
  logic        data_stall_o;

  logic        ram_re_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [3:0]  ram_mask_o;
  logic [31:0] ram_data_i;

  modport slave (
    input  inst_re_i, inst_addr_i,
    input  data_re_i, data_we_i, data_addr_i, data_wdata_i, data_mask_i,
    input  ram_data_i,
    output inst_data_o, inst_ack_o, inst_stall_o,
    output data_rdata_o, data_ack_o, data_stall_o,
    output ram_re_o, ram_we_o, ram_addr_o, ram_data_o, ram_mask_o
  );

  modport master (
    output inst_re_i, inst_addr_i,
    output data_re_i, data_we_i, data_addr_i, data_wdata_i, data_mask_i,
    output ram_data_i,
    input  inst_data_o, inst_ack_o, inst_stall_o,
    input  data_rdata_o, data_ack_o, data_stall_o,
    input  ram_re_o, ram_we_o, ram_addr_o, ram_data_o, ram_mask_o
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram_controller port between instruction fetch and data access.
// Each access is one fixed-length transaction: IDLE (grant) -> ACCESS (ACCESS_CYCLES) -> RESP (ack pulse).
// Data wins by default. A waiting fetch is forced through after MAX_DATA_STREAK back-to-back data grants.
module sram_arbiter #(
  parameter int ACCESS_CYCLES   = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);
  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int STK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic             owner_data_q, owner_data_d;  // 1: data port owns the access
  logic             op_we_q, op_we_d;
  logic             ram_re_q, ram_re_d;
  logic             ram_we_q, ram_we_d;
  logic [31:0]      ram_addr_q, ram_addr_d;
  logic [31:0]      ram_data_q, ram_data_d;
  logic [3:0]       ram_mask_q, ram_mask_d;
  logic [31:0]      inst_data_q, inst_data_d;
  logic [31:0]      data_rdata_q, data_rdata_d;
  logic             inst_ack_q, inst_ack_d;
  logic             data_ack_q, data_ack_d;

  logic data_req_s;
  logic grant_data_s;

  assign data_req_s   = bus.data_re_i | bus.data_we_i;
  assign grant_data_s = data_req_s & (~bus.inst_re_i | (streak_q < STK_MAX));

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    owner_data_d = owner_data_q;
    op_we_d      = op_we_q;
    ram_re_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_mask_d   = ram_mask_q;
    inst_data_d  = inst_data_q;
    data_rdata_d = data_rdata_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_data_s) begin
          state_d      = ACCESS;
          cnt_d        = CNT_INIT;
          owner_data_d = 1'b1;
          op_we_d      = bus.data_we_i;
          ram_we_d     = bus.data_we_i;
          ram_re_d     = ~bus.data_we_i;
          ram_addr_d   = bus.data_addr_i;
          ram_data_d   = bus.data_wdata_i;
          ram_mask_d   = bus.data_mask_i;
          // Only data grants taken while a fetch is waiting count toward the streak.
          if (bus.inst_re_i) begin
            streak_d = (streak_q < STK_MAX) ? (streak_q + STK_W'(1)) : streak_q;
          end else begin
            streak_d = '0;
          end
        end else if (bus.inst_re_i) begin
          state_d      = ACCESS;
          cnt_d        = CNT_INIT;
          owner_data_d = 1'b0;
          op_we_d      = 1'b0;
          ram_re_d     = 1'b1;
          ram_addr_d   = bus.inst_addr_i;
          streak_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          inst_ack_d = ~owner_data_q;
          data_ack_d = owner_data_q;
          // A read delivers the SRAM word to the owner only; a write captures nothing.
          if (!op_we_q && owner_data_q) begin
            data_rdata_d = bus.ram_data_i;
          end else if (!op_we_q) begin
            inst_data_d = bus.ram_data_i;
          end else begin
            data_rdata_d = data_rdata_q;
          end
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          ram_re_d = ~op_we_q;
          ram_we_d = op_we_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      streak_q     <= '0;
      owner_data_q <= 1'b0;
      op_we_q      <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= 32'h0000_0000;
      ram_data_q   <= 32'h0000_0000;
      ram_mask_q   <= 4'h0;
      inst_data_q  <= 32'h0000_0000;
      data_rdata_q <= 32'h0000_0000;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      owner_data_q <= owner_data_d;
      op_we_q      <= op_we_d;
      ram_re_q     <= ram_re_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_mask_q   <= ram_mask_d;
      inst_data_q  <= inst_data_d;
      data_rdata_q <= data_rdata_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
    end
  end

  assign bus.ram_re_o     = ram_re_q;
  assign bus.ram_we_o     = ram_we_q;
  assign bus.ram_addr_o   = ram_addr_q;
  assign bus.ram_data_o   = ram_data_q;
  assign bus.ram_mask_o   = ram_mask_q;
  assign bus.inst_data_o  = inst_data_q;
  assign bus.inst_ack_o   = inst_ack_q;
  assign bus.data_rdata_o = data_rdata_q;
  assign bus.data_ack_o   = data_ack_q;
  assign bus.inst_stall_o = bus.inst_re_i & ~inst_ack_q;
  assign bus.data_stall_o = data_req_s & ~data_ack_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter. It has three parts:
//  - a table of single transactions with hand-computed results;
//  - hand-written multi-cycle sequences for arbitration order, streak fairness and reset abort;
//  - randomized traffic checked against a transaction-level timeline model.
module tb_sram_arbiter;
  localparam int AC   = 2;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  sram_arbiter_if bus();

  sram_arbiter #(.ACCESS_CYCLES(AC), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram    [256];
  logic [31:0] ref_mem [256];
  bit          sram_init;

  typedef struct {
    logic        is_inst;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_inst_data;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = (i == 4) ? 32'h2402_0005 : (32'hC0DE_0000 | 32'(i));
    return w;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Behavioural SRAM: applies writes and presents read data on the falling edge.
  always @(negedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 256; i++) sram[i] = init_word(i);
    end else if (bus.ram_we_o) begin
      sram[bus.ram_addr_o[9:2]] = merge(sram[bus.ram_addr_o[9:2]], bus.ram_data_o, bus.ram_mask_o);
    end
    bus.ram_data_i = bus.ram_re_o ? sram[bus.ram_addr_o[9:2]] : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_reqs();
    bus.inst_re_i    = 1'b0;
    bus.data_re_i    = 1'b0;
    bus.data_we_i    = 1'b0;
  endtask

  // One isolated transaction from IDLE, checked cycle by cycle.
  task automatic do_txn(input string nm, input vec_t v);
    @(negedge clk);
    if (v.is_inst) begin
      bus.inst_re_i   = 1'b1;
      bus.inst_addr_i = v.addr;
    end else begin
      bus.data_re_i    = v.re;
      bus.data_we_i    = v.we;
      bus.data_addr_i  = v.addr;
      bus.data_wdata_i = v.wdata;
      bus.data_mask_i  = v.mask;
    end
    for (int k = 1; k <= AC + 1; k++) begin
      @(negedge clk);
      if (k <= AC) begin
        chk({nm, " ram_re"}, 32'(bus.ram_re_o), 32'(v.exp_re));
        chk({nm, " ram_we"}, 32'(bus.ram_we_o), 32'(v.exp_we));
        chk({nm, " ram_addr"}, bus.ram_addr_o, v.addr);
        chk({nm, " acks idle"}, {30'h0, bus.inst_ack_o, bus.data_ack_o}, 32'h0);
        chk({nm, " stall"}, 32'(v.is_inst ? bus.inst_stall_o : bus.data_stall_o), 32'h1);
        if (!v.is_inst) chk({nm, " ram_mask"}, 32'(bus.ram_mask_o), 32'(v.mask));
        if (v.exp_we)   chk({nm, " ram_data"}, bus.ram_data_o, v.wdata);
      end else begin
        chk({nm, " inst_ack"}, 32'(bus.inst_ack_o), 32'(v.is_inst));
        chk({nm, " data_ack"}, 32'(bus.data_ack_o), 32'(!v.is_inst));
        chk({nm, " ram op off"}, {30'h0, bus.ram_re_o, bus.ram_we_o}, 32'h0);
        chk({nm, " stall off"}, 32'(v.is_inst ? bus.inst_stall_o : bus.data_stall_o), 32'h0);
        chk({nm, " inst_data"}, bus.inst_data_o, v.exp_inst_data);
        chk({nm, " data_rdata"}, bus.data_rdata_o, v.exp_rdata);
      end
    end
    clear_reqs();
    @(negedge clk);
    chk({nm, " ack pulse ends"}, {30'h0, bus.inst_ack_o, bus.data_ack_o}, 32'h0);
  endtask

  // Randomized traffic against a transaction timeline model.
  task automatic run_random(input int ncyc);
    int          next_free, streak, t_start;
    bit          t_valid, t_data, t_we, act, ackc, e_iack, e_dack, dreq, gd;
    logic [31:0] t_addr, t_wdata, t_rd, m_inst, m_rdata, a;
    logic [3:0]  t_mask;
    logic [7:0]  r8;
    int          kind;
    next_free = 0; streak = 0; t_start = 0; t_valid = 1'b0; t_data = 1'b0; t_we = 1'b0;
    t_addr = 32'h0; t_wdata = 32'h0; t_rd = 32'h0; t_mask = 4'h0;
    m_inst = 32'h0; m_rdata = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      act    = t_valid && (c >= t_start + 1) && (c <= t_start + AC);
      ackc   = t_valid && (c == t_start + AC + 1);
      e_iack = ackc && !t_data;
      e_dack = ackc && t_data;
      if (ackc && !t_we) begin
        if (t_data) m_rdata = t_rd;
        else        m_inst  = t_rd;
      end
      chk("rnd ram_re", 32'(bus.ram_re_o), 32'(act && !t_we));
      chk("rnd ram_we", 32'(bus.ram_we_o), 32'(act && t_we));
      chk("rnd inst_ack", 32'(bus.inst_ack_o), 32'(e_iack));
      chk("rnd data_ack", 32'(bus.data_ack_o), 32'(e_dack));
      chk("rnd inst_data", bus.inst_data_o, m_inst);
      chk("rnd data_rdata", bus.data_rdata_o, m_rdata);
      chk("rnd inst_stall", 32'(bus.inst_stall_o), 32'(bus.inst_re_i && !e_iack));
      chk("rnd data_stall", 32'(bus.data_stall_o), 32'((bus.data_re_i || bus.data_we_i) && !e_dack));
      if (act) chk("rnd ram_addr", bus.ram_addr_o, t_addr);
      if (act && t_we) begin
        chk("rnd ram_data", bus.ram_data_o, t_wdata);
        chk("rnd ram_mask", 32'(bus.ram_mask_o), 32'(t_mask));
      end
      // Requesters: hold until acked, then maybe issue a new request later.
      if (e_iack) begin
        bus.inst_re_i = 1'b0;
      end else if (!bus.inst_re_i && ($urandom_range(0, 2) == 0)) begin
        r8 = 8'($urandom_range(0, 255));
        bus.inst_re_i   = 1'b1;
        bus.inst_addr_i = {22'h0, r8, 2'b00};
      end
      if (e_dack) begin
        bus.data_re_i = 1'b0;
        bus.data_we_i = 1'b0;
      end else if (!(bus.data_re_i || bus.data_we_i) && ($urandom_range(0, 2) == 0)) begin
        r8   = 8'($urandom_range(0, 255));
        kind = $urandom_range(0, 2);
        bus.data_re_i    = (kind != 1);
        bus.data_we_i    = (kind != 0);
        bus.data_addr_i  = {22'h0, r8, 2'b00};
        bus.data_wdata_i = $urandom;
        bus.data_mask_i  = 4'($urandom_range(0, 15));
      end
      // Grant decision on the requests sampled at the end of this cycle.
      dreq = bus.data_re_i || bus.data_we_i;
      if (c >= next_free && (dreq || bus.inst_re_i)) begin
        gd      = dreq && (!bus.inst_re_i || streak < MAXS);
        t_valid = 1'b1;
        t_start = c;
        t_data  = gd;
        if (gd) begin
          t_we    = bus.data_we_i;
          a       = bus.data_addr_i;
          t_wdata = bus.data_wdata_i;
          t_mask  = bus.data_mask_i;
          streak  = bus.inst_re_i ? ((streak < MAXS) ? streak + 1 : streak) : 0;
        end else begin
          t_we   = 1'b0;
          a      = bus.inst_addr_i;
          streak = 0;
        end
        t_addr = a;
        if (t_we) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], t_wdata, t_mask);
        else      t_rd = ref_mem[a[9:2]];
        next_free = c + AC + 2;
      end
    end
    clear_reqs();
  endtask

  initial begin : main
    int  d_at, i_at, nd, bad;
    byte order[$];

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,          4'h0, 1'b1, 1'b0, 32'h2402_0005, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 1'b0, 1'b1, 32'h2402_0005, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,          4'hF, 1'b1, 1'b0, 32'h2402_0005, 32'hC0DE_BEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 32'h2402_0005, 32'hC0DE_BEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,          4'h0, 1'b1, 1'b0, 32'h1234_5678, 32'hC0DE_BEEF};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,          4'h5, 1'b1, 1'b0, 32'h1234_5678, 32'hC0DE_0008};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h8, 1'b0, 1'b1, 32'h1234_5678, 32'hC0DE_0008};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0,          4'h0, 1'b1, 1'b0, 32'hAADE_0008, 32'hC0DE_0008};

    rst = 1'b0;
    sram_init = 1'b1;
    clear_reqs();
    bus.inst_addr_i = 32'h0; bus.data_addr_i = 32'h0;
    bus.data_wdata_i = 32'h0; bus.data_mask_i = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset ram_re", 32'(bus.ram_re_o), 32'h0);
    chk("reset ram_we", 32'(bus.ram_we_o), 32'h0);
    chk("reset ram_addr", bus.ram_addr_o, 32'h0);
    chk("reset ram_data", bus.ram_data_o, 32'h0);
    chk("reset ram_mask", 32'(bus.ram_mask_o), 32'h0);
    chk("reset acks", {30'h0, bus.inst_ack_o, bus.data_ack_o}, 32'h0);
    chk("reset inst_data", bus.inst_data_o, 32'h0);
    chk("reset data_rdata", bus.data_rdata_o, 32'h0);
    rst = 1'b1;
    sram_init = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous requests: data first, then inst.
    @(negedge clk);
    bus.inst_re_i = 1'b1; bus.inst_addr_i = 32'h0000_0010;
    bus.data_re_i = 1'b1; bus.data_addr_i = 32'h0000_0040;
    d_at = -1; i_at = -1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus.data_ack_o) begin d_at = k; bus.data_re_i = 1'b0; end
      if (bus.inst_ack_o) begin i_at = k; bus.inst_re_i = 1'b0; end
    end
    chk("simul data ack cycle", 32'(d_at), 32'd3);
    chk("simul inst ack cycle", 32'(i_at), 32'd7);
    chk("simul inst_data", bus.inst_data_o, 32'h2402_0005);
    chk("simul data_rdata", bus.data_rdata_o, 32'hC0DE_0010);

    // Streak fairness: data held continuously with a waiting fetch.
    @(negedge clk);
    bus.inst_re_i = 1'b1; bus.inst_addr_i = 32'h0000_0030;
    bus.data_re_i = 1'b1; bus.data_we_i = 1'b0; bus.data_addr_i = 32'h0000_0044;
    for (int k = 0; k < 80 && order.size() < 6; k++) begin
      @(negedge clk);
      if (bus.inst_ack_o) begin order.push_back(8'h49); bus.inst_re_i = 1'b0; end
      if (bus.data_ack_o) order.push_back(8'h44);
    end
    clear_reqs();
    chk("streak ack count", 32'(order.size()), 32'd6);
    if (order.size() >= 6) begin
      nd = 0;
      for (int k = 0; k < 4; k++) if (order[k] == 8'h44) nd++;
      chk("streak data acks before inst", 32'(nd), 32'd4);
      chk("streak 5th grant is inst", 32'(order[4]), 32'h49);
      chk("streak 6th grant is data", 32'(order[5]), 32'h44);
    end
    repeat (3) @(negedge clk);

    // Reset in the middle of an instruction read.
    @(negedge clk);
    bus.inst_re_i = 1'b1; bus.inst_addr_i = 32'h0000_0010;
    @(negedge clk);
    chk("abort access active", 32'(bus.ram_re_o), 32'h1);
    rst = 1'b0;
    #1;
    chk("abort ram_re", 32'(bus.ram_re_o), 32'h0);
    chk("abort ram_addr", bus.ram_addr_o, 32'h0);
    chk("abort acks", {30'h0, bus.inst_ack_o, bus.data_ack_o}, 32'h0);
    chk("abort inst_data", bus.inst_data_o, 32'h0);
    chk("abort data_rdata", bus.data_rdata_o, 32'h0);
    bus.inst_re_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.inst_ack_o || bus.data_ack_o) bad++;
    end
    chk("abort no ack after release", 32'(bad), 32'h0);
    do_txn("post-reset fetch", '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 1'b0,
                                 32'h2402_0005, 32'h0});

    // Fresh state for randomized traffic.
    @(negedge clk);
    rst = 1'b0; sram_init = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; sram_init = 1'b0;
    run_random(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
